// File: rtl/alu_pkg.sv
// Shared ALU constants: op-code/ROB widths, op encodings and the branch compare helper.
// Every file that decodes ops imports this package so the encodings live in one place.
package alu_pkg;

    localparam int OP_SIZE_LOG  = 6;
    localparam int ROB_SIZE_LOG = 4;

    typedef logic [OP_SIZE_LOG-1:0]  op_t;
    typedef logic [ROB_SIZE_LOG-1:0] robid_t;

    localparam op_t OP_NOP   = 6'd0;
    localparam op_t OP_LUI   = 6'd1;
    localparam op_t OP_AUIPC = 6'd2;
    localparam op_t OP_JAL   = 6'd3;
    localparam op_t OP_JALR  = 6'd4;
    localparam op_t OP_BEQ   = 6'd5;
    localparam op_t OP_BNE   = 6'd6;
    localparam op_t OP_BLT   = 6'd7;
    localparam op_t OP_BGE   = 6'd8;
    localparam op_t OP_BLTU  = 6'd9;
    localparam op_t OP_BGEU  = 6'd10;
    // Memory ops are executed by the SLB; the ALU treats them as unrecognised.
    localparam op_t OP_LB    = 6'd11;
    localparam op_t OP_LH    = 6'd12;
    localparam op_t OP_LW    = 6'd13;
    localparam op_t OP_LBU   = 6'd14;
    localparam op_t OP_LHU   = 6'd15;
    localparam op_t OP_SB    = 6'd16;
    localparam op_t OP_SH    = 6'd17;
    localparam op_t OP_SW    = 6'd18;
    localparam op_t OP_ADDI  = 6'd19;
    localparam op_t OP_SLTI  = 6'd20;
    localparam op_t OP_SLTIU = 6'd21;
    localparam op_t OP_XORI  = 6'd22;
    localparam op_t OP_ORI   = 6'd23;
    localparam op_t OP_ANDI  = 6'd24;
    localparam op_t OP_SLLI  = 6'd25;
    localparam op_t OP_SRLI  = 6'd26;
    localparam op_t OP_SRAI  = 6'd27;
    localparam op_t OP_ADD   = 6'd28;
    localparam op_t OP_SUB   = 6'd29;
    localparam op_t OP_SLL   = 6'd30;
    localparam op_t OP_SLT   = 6'd31;
    localparam op_t OP_SLTU  = 6'd32;
    localparam op_t OP_XOR   = 6'd33;
    localparam op_t OP_SRL   = 6'd34;
    localparam op_t OP_SRA   = 6'd35;
    localparam op_t OP_OR    = 6'd36;
    localparam op_t OP_AND   = 6'd37;

    function automatic logic is_branch(input op_t op);
        return (op == OP_BEQ)  || (op == OP_BNE)  || (op == OP_BLT) ||
               (op == OP_BGE)  || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

    // Condition outcome for the six conditional branches; 0 for anything else.
    function automatic logic branch_taken(input op_t op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic res;
        res = 1'b0;
        case (op)
            OP_BEQ:  res = (a == b);
            OP_BNE:  res = (a != b);
            OP_BLT:  res = ($signed(a) <  $signed(b));
            OP_BGE:  res = ($signed(a) >= $signed(b));
            OP_BLTU: res = (a <  b);
            OP_BGEU: res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU: combinational compute feeding one registered CDB stage.
// Accepts one op per cycle with no back-pressure; rdy=0 freezes the output stage.
module alu
    import alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    pred_fail_flag,
    input  logic                    ALU_enable,
    input  logic [OP_SIZE_LOG-1:0]  op_to_ALU,
    input  logic [31:0]             vj_to_ALU,
    input  logic [31:0]             vk_to_ALU,
    input  logic [31:0]             imm_to_ALU,
    input  logic [ROB_SIZE_LOG-1:0] robid_to_ALU,
    input  logic [31:0]             curpc_to_ALU,
    output logic                    ALU_valid,
    output logic [31:0]             ALU_value,
    output logic [ROB_SIZE_LOG-1:0] ALU_robid,
    output logic [31:0]             ALU_next_pc,
    output logic                    ALU_taken
);

    logic [31:0] vj, vk, imm, pc;
    logic [31:0] pc_plus4, pc_plus_imm;
    logic [4:0]  shamt_r, shamt_i;
    logic [31:0] res_value, res_next_pc;
    logic        res_taken;

    assign vj          = vj_to_ALU;
    assign vk          = vk_to_ALU;
    assign imm         = imm_to_ALU;
    assign pc          = curpc_to_ALU;
    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;
    assign shamt_r     = vk[4:0];
    assign shamt_i     = imm[4:0];

    // Defaults cover non-control and unrecognised ops: value 0, fall through to pc+4.
    always_comb begin
        res_value   = 32'd0;
        res_next_pc = pc_plus4;
        res_taken   = 1'b0;
        case (op_to_ALU)
            OP_ADD:   res_value = vj + vk;
            OP_SUB:   res_value = vj - vk;
            OP_XOR:   res_value = vj ^ vk;
            OP_OR:    res_value = vj | vk;
            OP_AND:   res_value = vj & vk;
            OP_SLL:   res_value = vj << shamt_r;
            OP_SRL:   res_value = vj >> shamt_r;
            OP_SRA:   res_value = $unsigned($signed(vj) >>> shamt_r);
            OP_SLT:   res_value = {31'd0, $signed(vj) < $signed(vk)};
            OP_SLTU:  res_value = {31'd0, vj < vk};
            OP_ADDI:  res_value = vj + imm;
            OP_XORI:  res_value = vj ^ imm;
            OP_ORI:   res_value = vj | imm;
            OP_ANDI:  res_value = vj & imm;
            OP_SLLI:  res_value = vj << shamt_i;
            OP_SRLI:  res_value = vj >> shamt_i;
            OP_SRAI:  res_value = $unsigned($signed(vj) >>> shamt_i);
            OP_SLTI:  res_value = {31'd0, $signed(vj) < $signed(imm)};
            OP_SLTIU: res_value = {31'd0, vj < imm};
            OP_LUI:   res_value = imm;
            OP_AUIPC: res_value = pc_plus_imm;
            OP_JAL: begin
                res_value   = pc_plus4;
                res_next_pc = pc_plus_imm;
                res_taken   = 1'b1;
            end
            OP_JALR: begin
                res_value   = pc_plus4;
                res_next_pc = (vj + imm) & ~32'd1;
                res_taken   = 1'b1;
            end
            default: begin
                if (is_branch(op_to_ALU)) begin
                    res_taken   = branch_taken(op_to_ALU, vj, vk);
                    res_next_pc = res_taken ? pc_plus_imm : pc_plus4;
                end
            end
        endcase
    end

    // rst beats flush beats rdy; a flush kills only the valid/taken bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_valid   <= 1'b0;
            ALU_taken   <= 1'b0;
            ALU_value   <= 32'd0;
            ALU_robid   <= '0;
            ALU_next_pc <= 32'd0;
        end else if (pred_fail_flag) begin
            ALU_valid <= 1'b0;
            ALU_taken <= 1'b0;
        end else if (rdy) begin
            if (ALU_enable) begin
                ALU_valid   <= 1'b1;
                ALU_value   <= res_value;
                ALU_robid   <= robid_to_ALU;
                ALU_next_pc <= res_next_pc;
                ALU_taken   <= res_taken;
            end else begin
                ALU_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the single-cycle ALU.
module tb_alu;
    import alu_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst, rdy, pred_fail_flag, ALU_enable;
    logic [OP_SIZE_LOG-1:0]  op_to_ALU;
    logic [31:0]             vj_to_ALU, vk_to_ALU, imm_to_ALU, curpc_to_ALU;
    logic [ROB_SIZE_LOG-1:0] robid_to_ALU;
    logic                    ALU_valid, ALU_taken;
    logic [31:0]             ALU_value, ALU_next_pc;
    logic [ROB_SIZE_LOG-1:0] ALU_robid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [OP_SIZE_LOG-1:0] op;
        logic [31:0] vj, vk, imm, pc, value, npc;
        logic taken;
    } vec_t;

    alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pred_fail_flag(pred_fail_flag),
        .ALU_enable(ALU_enable), .op_to_ALU(op_to_ALU), .vj_to_ALU(vj_to_ALU),
        .vk_to_ALU(vk_to_ALU), .imm_to_ALU(imm_to_ALU), .robid_to_ALU(robid_to_ALU),
        .curpc_to_ALU(curpc_to_ALU), .ALU_valid(ALU_valid), .ALU_value(ALU_value),
        .ALU_robid(ALU_robid), .ALU_next_pc(ALU_next_pc), .ALU_taken(ALU_taken)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic [OP_SIZE_LOG-1:0] op,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [ROB_SIZE_LOG-1:0] rid);
        ALU_enable = en; op_to_ALU = op; vj_to_ALU = vj; vk_to_ALU = vk;
        imm_to_ALU = imm; curpc_to_ALU = pc; robid_to_ALU = rid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; pred_fail_flag = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 32'h10, 4'd3);
        tick(); tick();
        n_checks++;
        if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken} !== {1'b0, 32'd0, 4'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got v=%b val=%h rid=%h npc=%h tk=%b, want all zero",
                     ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken);
        end
        rst = 1'b0; rdy = 1'b1; pred_fail_flag = 1'b0;
    endtask

    // Back-to-back stream of non-control ops, one per cycle.
    task automatic test_arith();
        vec_t v[22];
        v[0]  = '{OP_ADD,   32'hFFFFFFFF, 32'd2,        32'd0,        32'h1000, 32'h00000001, 32'h1004, 1'b0};
        v[1]  = '{OP_SUB,   32'd5,        32'd7,        32'd0,        32'h1000, 32'hFFFFFFFE, 32'h1004, 1'b0};
        v[2]  = '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h1000, 32'h0FF00FF0, 32'h1004, 1'b0};
        v[3]  = '{OP_OR,    32'h00000F00, 32'h000000F0, 32'd0,        32'h1000, 32'h00000FF0, 32'h1004, 1'b0};
        v[4]  = '{OP_AND,   32'hFF00FF00, 32'h0FF00FF0, 32'd0,        32'h1000, 32'h0F000F00, 32'h1004, 1'b0};
        v[5]  = '{OP_ADDI,  32'd10,       32'd0,        32'hFFFFFFFF, 32'h1000, 32'd9,        32'h1004, 1'b0};
        v[6]  = '{OP_XORI,  32'h0000FFFF, 32'd0,        32'hFFFFFFFF, 32'h1000, 32'hFFFF0000, 32'h1004, 1'b0};
        v[7]  = '{OP_ORI,   32'h12345678, 32'd0,        32'h000000FF, 32'h1000, 32'h123456FF, 32'h1004, 1'b0};
        v[8]  = '{OP_ANDI,  32'h12345678, 32'd0,        32'h000000FF, 32'h1000, 32'h00000078, 32'h1004, 1'b0};
        v[9]  = '{OP_SLL,   32'd1,        32'h24,       32'd0,        32'h1000, 32'h00000010, 32'h1004, 1'b0};
        v[10] = '{OP_SRL,   32'h80000000, 32'd31,       32'd0,        32'h1000, 32'h00000001, 32'h1004, 1'b0};
        v[11] = '{OP_SRA,   32'h80000000, 32'd4,        32'd0,        32'h1000, 32'hF8000000, 32'h1004, 1'b0};
        v[12] = '{OP_SLLI,  32'd3,        32'd0,        32'h21,       32'h1000, 32'h00000006, 32'h1004, 1'b0};
        v[13] = '{OP_SRAI,  32'h80000000, 32'd0,        32'h41F,      32'h1000, 32'hFFFFFFFF, 32'h1004, 1'b0};
        v[14] = '{OP_SRLI,  32'h80000000, 32'd0,        32'h41F,      32'h1000, 32'h00000001, 32'h1004, 1'b0};
        v[15] = '{OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'd0,        32'h1000, 32'd1,        32'h1004, 1'b0};
        v[16] = '{OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        32'h1000, 32'd0,        32'h1004, 1'b0};
        v[17] = '{OP_SLTI,  32'hFFFFFFFE, 32'd0,        32'd1,        32'h1000, 32'd1,        32'h1004, 1'b0};
        v[18] = '{OP_SLTIU, 32'hFFFFFFFE, 32'd0,        32'd1,        32'h1000, 32'd0,        32'h1004, 1'b0};
        v[19] = '{OP_LUI,   32'hDEADBEEF, 32'd0,        32'h12345000, 32'h1000, 32'h12345000, 32'h1004, 1'b0};
        v[20] = '{OP_AUIPC, 32'd0,        32'd0,        32'h00002000, 32'h1000, 32'h00003000, 32'h1004, 1'b0};
        v[21] = '{OP_SRA,   32'h7FFFFFFF, 32'd30,       32'd0,        32'h1000, 32'h00000001, 32'h1004, 1'b0};
        for (int i = 0; i < 22; i++) begin
            logic [ROB_SIZE_LOG-1:0] rid;
            rid = (i == 0) ? 4'd5 : ROB_SIZE_LOG'(i);
            drive(1'b1, v[i].op, v[i].vj, v[i].vk, v[i].imm, v[i].pc, rid);
            tick();
            n_checks++;
            if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken} !==
                {1'b1, v[i].value, rid, v[i].npc, v[i].taken}) begin
                n_fail++;
                $display("FAIL arith[%0d] op=%0d: got v=%b val=%h rid=%h npc=%h tk=%b, want v=1 val=%h rid=%h npc=%h tk=%b",
                         i, v[i].op, ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken,
                         v[i].value, rid, v[i].npc, v[i].taken);
            end
        end
        drive(1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic test_control();
        vec_t v[10];
        v[0] = '{OP_JAL,  32'd0,        32'd0,        32'h40,       32'h200, 32'h204, 32'h240,  1'b1};
        v[1] = '{OP_JALR, 32'h2003,     32'd0,        32'd4,        32'h100, 32'h104, 32'h2006, 1'b1};
        v[2] = '{OP_BLT,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFF8, 32'h40,  32'd0,   32'h38,   1'b1};
        v[3] = '{OP_BLTU, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFF8, 32'h40,  32'd0,   32'h44,   1'b0};
        v[4] = '{OP_BEQ,  32'd5,        32'd5,        32'h10,       32'h80,  32'd0,   32'h90,   1'b1};
        v[5] = '{OP_BNE,  32'd5,        32'd5,        32'h10,       32'h80,  32'd0,   32'h84,   1'b0};
        v[6] = '{OP_BGE,  32'd0,        32'hFFFFFFFF, 32'h10,       32'h80,  32'd0,   32'h90,   1'b1};
        v[7] = '{OP_BGEU, 32'd0,        32'hFFFFFFFF, 32'h10,       32'h80,  32'd0,   32'h84,   1'b0};
        v[8] = '{6'h3F,   32'h1234,     32'h5678,     32'h10,       32'h300, 32'd0,   32'h304,  1'b0};
        v[9] = '{OP_LW,   32'h1234,     32'h5678,     32'h10,       32'h300, 32'd0,   32'h304,  1'b0};
        for (int i = 0; i < 10; i++) begin
            logic [ROB_SIZE_LOG-1:0] rid;
            rid = ROB_SIZE_LOG'(15 - i);
            drive(1'b1, v[i].op, v[i].vj, v[i].vk, v[i].imm, v[i].pc, rid);
            tick();
            n_checks++;
            if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken} !==
                {1'b1, v[i].value, rid, v[i].npc, v[i].taken}) begin
                n_fail++;
                $display("FAIL control[%0d] op=%0d: got v=%b val=%h rid=%h npc=%h tk=%b, want v=1 val=%h rid=%h npc=%h tk=%b",
                         i, v[i].op, ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken,
                         v[i].value, rid, v[i].npc, v[i].taken);
            end
        end
        drive(1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic test_flush();
        drive(1'b1, OP_JAL, 32'd0, 32'd0, 32'h40, 32'h200, 4'd2);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_taken} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_pre: got v=%b tk=%b, want 1 1", ALU_valid, ALU_taken);
        end
        pred_fail_flag = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 32'h10, 4'd3);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_taken} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%b tk=%b, want 0 0", ALU_valid, ALU_taken);
        end
        pred_fail_flag = 1'b0;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 32'h10, 4'd4);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken} !== {1'b1, 32'd3, 4'd4, 32'h14, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b val=%h rid=%h npc=%h tk=%b, want 1 3 4 14 0",
                     ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken);
        end
        // A flush must also clear valid while the pipeline is stalled.
        rdy = 1'b0; pred_fail_flag = 1'b1;
        tick();
        n_checks++;
        if (ALU_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stalled: got v=%b, want 0", ALU_valid);
        end
        rdy = 1'b1; pred_fail_flag = 1'b0;
        drive(1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, OP_ADD, 32'd7, 32'd8, 32'd0, 32'h20, 4'd9);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_value, ALU_robid} !== {1'b1, 32'd15, 4'd9}) begin
            n_fail++;
            $display("FAIL stall_pre: got v=%b val=%h rid=%h, want 1 f 9", ALU_valid, ALU_value, ALU_robid);
        end
        rdy = 1'b0;
        drive(1'b1, OP_SUB, 32'd100, 32'd1, 32'd0, 32'h24, 4'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc} !== {1'b1, 32'd15, 4'd9, 32'h24}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b val=%h rid=%h npc=%h, want 1 f 9 24",
                         c, ALU_valid, ALU_value, ALU_robid, ALU_next_pc);
            end
        end
        rdy = 1'b1;
        drive(1'b0, OP_SUB, 32'd100, 32'd1, 32'd0, 32'h24, 4'd1);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_value, ALU_robid} !== {1'b0, 32'd15, 4'd9}) begin
            n_fail++;
            $display("FAIL stall_idle: got v=%b val=%h rid=%h, want 0 f 9", ALU_valid, ALU_value, ALU_robid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_JAL, 32'd0, 32'd0, 32'h80, 32'h400, 4'd7);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_taken, ALU_next_pc} !== {1'b1, 1'b1, 32'h480}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got v=%b tk=%b npc=%h, want 1 1 480", ALU_valid, ALU_taken, ALU_next_pc);
        end
        rst = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 32'h500, 4'd6);
        tick();
        n_checks++;
        if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken} !== {1'b0, 32'd0, 4'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid: got v=%b val=%h rid=%h npc=%h tk=%b, want all zero",
                     ALU_valid, ALU_value, ALU_robid, ALU_next_pc, ALU_taken);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({ALU_valid, ALU_value, ALU_robid, ALU_next_pc} !== {1'b1, 32'd2, 4'd6, 32'h504}) begin
            n_fail++;
            $display("FAIL rstmid_after: got v=%b val=%h rid=%h npc=%h, want 1 2 6 504",
                     ALU_valid, ALU_value, ALU_robid, ALU_next_pc);
        end
        drive(1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_control();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
